bus_control_unit_pq: RTL

//  Parametrised NEC bus control unit that sequences all external bus cycles (prefetch, memory, I/O) on a 20-bit address / 16-bit data bus.

---
 rtl/bus_control_unit_pq.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_control_unit_pq.sv
// bus_control_unit_pq: bus control unit for a 20-bit address / 16-bit data bus.
// It sequences prefetch, memory and I/O bus cycles (IDLE -> T1 -> T2 -> [TW]* -> T3).
// It also owns a power-of-two instruction prefetch queue.
// Optional feature macro: BCU_WAIT_GEN_EN adds the wait_cfg port and internal TW states.
//
// Ports:
//   clk, n_reset          clock, asynchronous active-low reset
//   ce_1 / ce_2           phase enables: ce_1 samples, ce_2 advances the T-state
//   ready                 external ready, sampled on ce_1 in T3
//   r_w, n_ube, n_mreq    bus direction, upper byte enable, cycle-in-progress
//   n_mstb, n_iostb       memory / I/O strobes
//   addr, dout, din       bus address, write data (lane-aligned), read data
//   reg_ps, pfp_set       program segment; reload of the prefetch pointer from ipq_head
//   block_prefetch        inhibits new prefetch cycles
//   ipq_head              EU consume pointer
//   ipq_bytes, ipq_len    queue storage and valid byte count
//   dp_*                  EU data port: address, write data, read data, {io,wide,write}, request,
//                         ready
//   wait_cfg              {io_waits, mem_waits}; only with BCU_WAIT_GEN_EN
module bus_control_unit_pq #(
  parameter int unsigned IPQ_DEPTH       = 8,
  parameter int unsigned PREFETCH_THRESH = 4,
  parameter int unsigned WAIT_W          = 3,
  localparam int unsigned LW             = $clog2(IPQ_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   ce_1,
  input  logic                   ce_2,
  input  logic                   ready,
  output logic                   r_w,
  output logic                   n_ube,
  output logic                   n_mreq,
  output logic                   n_mstb,
  output logic                   n_iostb,
  output logic [19:0]            addr,
  output logic [15:0]            dout,
  input  logic [15:0]            din,
  input  logic [15:0]            reg_ps,
  input  logic                   pfp_set,
  input  logic                   block_prefetch,
  input  logic [15:0]            ipq_head,
  output logic [8*IPQ_DEPTH-1:0] ipq_bytes,
  output logic [LW-1:0]          ipq_len,
  input  logic [19:0]            dp_addr,
  input  logic [15:0]            dp_dout,
  output logic [15:0]            dp_din,
  input  logic [2:0]             dp_cmd,
  input  logic                   dp_req,
  output logic                   dp_ready
`ifdef BCU_WAIT_GEN_EN
  ,
  input  logic [2*WAIT_W-1:0]    wait_cfg
`endif
);

  localparam int unsigned IW = $clog2(IPQ_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StT1,
    StT2,
`ifdef BCU_WAIT_GEN_EN
    StTw,
`endif
    StT3
  } t_state_e;

  t_state_e    state_q, state_d;
  logic        r_w_q, r_w_d, n_ube_q, n_ube_d;
  logic        n_mreq_q, n_mreq_d, n_mstb_q, n_mstb_d, n_iostb_q, n_iostb_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d, pfp_q, pfp_d, dp_din_q, dp_din_d;
  logic [7:0]  ipq_q [IPQ_DEPTH];
  logic [7:0]  ipq_d [IPQ_DEPTH];
  logic [7:0]  lo_byte_q, lo_byte_d;       // first-cycle din[15:8] of an odd word read
  logic        discard_q, discard_d, dp_busy_q, dp_busy_d, latched_q, latched_d;
  logic        cyc_pf_q, cyc_pf_d, cyc_io_q, cyc_io_d, odd_q, odd_d;
  logic        split_q, split_d, half2_q, half2_d, sec_pend_q, sec_pend_d;
`ifdef BCU_WAIT_GEN_EN
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_sel;
`endif

  logic          idle_ce2, t3_done, fin, pf_room, issue_sec, issue_dp, issue_pf;
  logic [15:0]   rd_data;
  logic [IW-1:0] wr_idx0, wr_idx1;
  logic          unused_head;

  assign unused_head = ^ipq_head[15:LW];

  assign ipq_len  = pfp_set ? '0 : (pfp_q[LW-1:0] - ipq_head[LW-1:0]);
  assign pf_room  = (ipq_len <= LW'(IPQ_DEPTH - PREFETCH_THRESH));
  assign idle_ce2 = (state_q == StIdle) & ce_2;
  assign t3_done  = (state_q == StT3) & ce_1 & ready;
  // Final cycle of a data transfer: not a prefetch and not the first half of a split word.
  assign fin      = t3_done & ~cyc_pf_q & ~(split_q & ~half2_q);

  // Arbitration priority: split second half, then data request, then prefetch.
  assign issue_sec = idle_ce2 & sec_pend_q;
  assign issue_dp  = idle_ce2 & ~sec_pend_q & (dp_req | latched_q);
  assign issue_pf  = idle_ce2 & ~sec_pend_q & ~(dp_req | latched_q) & ~block_prefetch &
                     ~pfp_set & pf_room;

  assign rd_data = ~odd_q  ? din :
                   split_q ? {din[7:0], lo_byte_q} : {din[7:0], din[15:8]};

  assign wr_idx0 = pfp_q[IW-1:0];
  assign wr_idx1 = wr_idx0 + IW'(1);

`ifdef BCU_WAIT_GEN_EN
  assign wait_sel = cyc_io_q ? wait_cfg[2*WAIT_W-1:WAIT_W] : wait_cfg[WAIT_W-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    r_w_d      = r_w_q;
    n_ube_d    = n_ube_q;
    n_mreq_d   = n_mreq_q;
    n_mstb_d   = n_mstb_q;
    n_iostb_d  = n_iostb_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    pfp_d      = pfp_q;
    dp_din_d   = dp_din_q;
    lo_byte_d  = lo_byte_q;
    discard_d  = discard_q;
    dp_busy_d  = dp_busy_q;
    latched_d  = latched_q;
    cyc_pf_d   = cyc_pf_q;
    cyc_io_d   = cyc_io_q;
    odd_d      = odd_q;
    split_d    = split_q;
    half2_d    = half2_q;
    sec_pend_d = sec_pend_q;
    ipq_d      = ipq_q;
`ifdef BCU_WAIT_GEN_EN
    wait_cnt_d = wait_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (ce_2) begin
          n_mreq_d  = 1'b1;
          n_mstb_d  = 1'b1;
          n_iostb_d = 1'b1;
          if (issue_sec | issue_dp | issue_pf) state_d = StT1;
        end
      end
      StT1: begin
        if (ce_1)      n_mreq_d = 1'b0;
        else if (ce_2) state_d  = StT2;
      end
      StT2: begin
        if (ce_1) begin
          if (cyc_io_q) n_iostb_d = 1'b0;
          else          n_mstb_d  = 1'b0;
        end else if (ce_2) begin
`ifdef BCU_WAIT_GEN_EN
          if (wait_sel != '0) begin
            state_d    = StTw;
            wait_cnt_d = wait_sel - WAIT_W'(1);
          end else begin
            state_d = StT3;
          end
`else
          state_d = StT3;
`endif
        end
      end
`ifdef BCU_WAIT_GEN_EN
      StTw: begin
        if (ce_2) begin
          if (wait_cnt_q == '0) state_d    = StT3;
          else                  wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
`endif
      StT3: begin
        if (ce_1 & ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (issue_sec) begin
      addr_d     = addr_q + 20'd1;
      n_ube_d    = 1'b1;
      half2_d    = 1'b1;
      sec_pend_d = 1'b0;
    end

    if (issue_dp) begin
      addr_d    = dp_addr;
      r_w_d     = ~dp_cmd[0];
      n_ube_d   = ~(dp_cmd[1] | dp_addr[0]);
      dout_d    = dp_addr[0] ? {dp_dout[7:0], dp_dout[15:8]} : dp_dout;
      cyc_pf_d  = 1'b0;
      cyc_io_d  = dp_cmd[2];
      odd_d     = dp_addr[0];
      split_d   = dp_cmd[1] & dp_addr[0];
      half2_d   = 1'b0;
      dp_busy_d = 1'b1;
      latched_d = 1'b0;
    end else if (dp_req) begin
      latched_d = 1'b1;
    end

    if (issue_pf) begin
      addr_d    = {reg_ps, 4'h0} + {4'h0, pfp_q};
      r_w_d     = 1'b1;
      n_ube_d   = 1'b0;
      cyc_pf_d  = 1'b1;
      cyc_io_d  = 1'b0;
      discard_d = 1'b0;
    end

    if (t3_done) begin
      if (cyc_pf_q) begin
        if (~discard_q & ~pfp_set) begin
          if (pfp_q[0]) begin
            ipq_d[wr_idx0] = din[15:8];
            pfp_d          = pfp_q + 16'd1;
          end else begin
            ipq_d[wr_idx0] = din[7:0];
            ipq_d[wr_idx1] = din[15:8];
            pfp_d          = pfp_q + 16'd2;
          end
        end
      end else if (split_q & ~half2_q) begin
        sec_pend_d = 1'b1;
        lo_byte_d  = din[15:8];
      end else begin
        dp_busy_d = 1'b0;
        dp_din_d  = rd_data;
      end
    end

    // Reload wins over any queue update; the in-flight fetch is marked stale.
    if (pfp_set) begin
      pfp_d     = ipq_head;
      discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= StIdle;
      r_w_q      <= 1'b1;
      n_ube_q    <= 1'b1;
      n_mreq_q   <= 1'b1;
      n_mstb_q   <= 1'b1;
      n_iostb_q  <= 1'b1;
      addr_q     <= '0;
      dout_q     <= '0;
      pfp_q      <= '0;
      dp_din_q   <= '0;
      lo_byte_q  <= '0;
      discard_q  <= 1'b0;
      dp_busy_q  <= 1'b0;
      latched_q  <= 1'b0;
      cyc_pf_q   <= 1'b0;
      cyc_io_q   <= 1'b0;
      odd_q      <= 1'b0;
      split_q    <= 1'b0;
      half2_q    <= 1'b0;
      sec_pend_q <= 1'b0;
      for (int i = 0; i < IPQ_DEPTH; i++) ipq_q[i] <= '0;
`ifdef BCU_WAIT_GEN_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      r_w_q      <= r_w_d;
      n_ube_q    <= n_ube_d;
      n_mreq_q   <= n_mreq_d;
      n_mstb_q   <= n_mstb_d;
      n_iostb_q  <= n_iostb_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      pfp_q      <= pfp_d;
      dp_din_q   <= dp_din_d;
      lo_byte_q  <= lo_byte_d;
      discard_q  <= discard_d;
      dp_busy_q  <= dp_busy_d;
      latched_q  <= latched_d;
      cyc_pf_q   <= cyc_pf_d;
      cyc_io_q   <= cyc_io_d;
      odd_q      <= odd_d;
      split_q    <= split_d;
      half2_q    <= half2_d;
      sec_pend_q <= sec_pend_d;
      ipq_q      <= ipq_d;
`ifdef BCU_WAIT_GEN_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  for (genvar i = 0; i < IPQ_DEPTH; i++) begin : g_ipq_out
    assign ipq_bytes[8*i +: 8] = ipq_q[i];
  end

  assign r_w      = r_w_q;
  assign n_ube    = n_ube_q;
  assign n_mreq   = n_mreq_q;
  assign n_mstb   = n_mstb_q;
  assign n_iostb  = n_iostb_q;
  assign addr     = addr_q;
  assign dout     = dout_q;
  // Read data and ready are visible combinationally in the completing cycle.
  assign dp_din   = fin ? rd_data : dp_din_q;
  assign dp_ready = ~dp_req & ~latched_q & (~dp_busy_q | fin);

endmodule
